// File: rtl/magnitude_scheduler.sv
// Round-robin scheduler sharing one fixed-latency magnitude engine among NUM_CH requesters.
// Each result comes back with its channel ID, and an enable/drain FSM stops issue without losing in-flight samples.
module magnitude_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int LATENCY    = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_enable,
  input  logic [NUM_CH-1:0]            i_ch_en,
  input  logic [NUM_CH-1:0]            i_req_valid,
  output logic [NUM_CH-1:0]            o_req_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_req_re,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_req_im,
  output logic [DATA_WIDTH-1:0]        o_eng_re,
  output logic [DATA_WIDTH-1:0]        o_eng_im,
  input  logic [DATA_WIDTH-1:0]        i_eng_mag,
  output logic                         o_out_valid,
  output logic [CH_W-1:0]              o_out_ch,
  output logic [DATA_WIDTH-1:0]        o_out_mag,
  output logic                         o_busy,
  output logic [31:0]                  o_sample_cnt,
  output logic [1:0]                   o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [CH_W-1:0]               ptr_q, ptr_d;
  logic [LATENCY-1:0]            tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0][CH_W-1:0]  tag_ch_q, tag_ch_d;
  logic                          out_valid_q, out_valid_d;
  logic [CH_W-1:0]               out_ch_q, out_ch_d;
  logic [DATA_WIDTH-1:0]         out_mag_q, out_mag_d;
  logic [31:0]                   cnt_q, cnt_d;

  logic                          issue_en;
  logic [NUM_CH-1:0]             elig;
  logic                          grant_any;
  logic [CH_W-1:0]               grant_ch;
  logic [CH_W-1:0]               cand;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DRAIN waits only on the tag pipeline, never on i_enable.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_enable) state_d = ST_RUN;
      ST_RUN:   if (!i_enable) state_d = ST_DRAIN;
      ST_DRAIN: if (!(|tag_vld_q)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; issue stops in the very cycle i_enable falls.
  always_comb begin
    issue_en    = (state_q == ST_RUN) && i_enable;
    o_busy      = (state_q != ST_IDLE) || (|tag_vld_q);
    o_dbg_state = state_q;
  end

  // Handshake: a request transfers in a cycle where i_req_valid[k] & o_req_ready[k];
  // ready is one-hot or zero and only ever points at a valid, unmasked channel.
  always_comb begin
    elig      = i_req_valid & i_ch_en;
    grant_any = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    if (issue_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cand = CH_W'((int'(ptr_q) + i) % NUM_CH);
        if (!grant_any && elig[cand]) begin
          grant_any = 1'b1;
          grant_ch  = cand;
        end
      end
    end
  end

  always_comb begin
    o_req_ready = grant_any ? (NUM_CH'(1) << grant_ch) : '0;
    o_eng_re    = grant_any ? i_req_re[grant_ch*DATA_WIDTH +: DATA_WIDTH] : '0;
    o_eng_im    = grant_any ? i_req_im[grant_ch*DATA_WIDTH +: DATA_WIDTH] : '0;
    ptr_d       = ptr_q;
    if (grant_any) begin
      ptr_d = (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + 1'b1;
    end
  end

  // Tags ride alongside the engine pipeline so each result knows its channel.
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_ch_d     = tag_ch_q;
    tag_vld_d[0] = grant_any;
    tag_ch_d[0]  = grant_ch;
    for (int s = 1; s < LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_ch_d[s]  = tag_ch_q[s-1];
    end
  end

  always_comb begin
    out_valid_d = tag_vld_q[LATENCY-1];
    out_ch_d    = out_ch_q;
    out_mag_d   = out_mag_q;
    cnt_d       = cnt_q;
    if (tag_vld_q[LATENCY-1]) begin
      out_ch_d  = tag_ch_q[LATENCY-1];
      out_mag_d = i_eng_mag;
      cnt_d     = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q       <= '0;
      tag_vld_q   <= '0;
      tag_ch_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_mag_q   <= '0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      tag_vld_q   <= tag_vld_d;
      tag_ch_q    <= tag_ch_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_mag_q   <= out_mag_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_out_valid  = out_valid_q;
  assign o_out_ch     = out_ch_q;
  assign o_out_mag    = out_mag_q;
  assign o_sample_cnt = cnt_q;

endmodule

// File: tb/tb_magnitude_scheduler.sv
// Bench for magnitude_scheduler: directed scenarios then random traffic, checked every cycle
// against a transaction-level model (search order, expected-result queue, drain bookkeeping).
module tb_magnitude_scheduler;
  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int LAT = 2;
  localparam int SBW = 64;
  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_DRAIN = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 i_enable;
  logic [NCH-1:0]       i_ch_en;
  logic [NCH-1:0]       i_req_valid;
  logic [NCH-1:0]       o_req_ready;
  logic [NCH*DW-1:0]    i_req_re;
  logic [NCH*DW-1:0]    i_req_im;
  logic [DW-1:0]        o_eng_re;
  logic [DW-1:0]        o_eng_im;
  logic [DW-1:0]        i_eng_mag;
  logic                 o_out_valid;
  logic [CHW-1:0]       o_out_ch;
  logic [DW-1:0]        o_out_mag;
  logic                 o_busy;
  logic [31:0]          o_sample_cnt;
  logic [1:0]           o_dbg_state;

  logic signed [DW-1:0] re_a [NCH];
  logic signed [DW-1:0] im_a [NCH];

  always_comb begin
    i_req_re = '0;
    i_req_im = '0;
    for (int k = 0; k < NCH; k++) begin
      i_req_re[k*DW +: DW] = re_a[k];
      i_req_im[k*DW +: DW] = im_a[k];
    end
  end

  magnitude_scheduler #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CH_W(CHW), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(i_enable), .i_ch_en(i_ch_en),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_re(i_req_re), .i_req_im(i_req_im),
    .o_eng_re(o_eng_re), .o_eng_im(o_eng_im), .i_eng_mag(i_eng_mag),
    .o_out_valid(o_out_valid), .o_out_ch(o_out_ch), .o_out_mag(o_out_mag),
    .o_busy(o_busy), .o_sample_cnt(o_sample_cnt), .o_dbg_state(o_dbg_state)
  );

  // Magnitude approximation: max + 3/8 * min of the absolute values.
  function automatic logic [DW-1:0] mag_f(input logic signed [DW-1:0] re,
                                          input logic signed [DW-1:0] im);
    int a, b, mx, mn;
    a  = (re < 0) ? -int'(re) : int'(re);
    b  = (im < 0) ? -int'(im) : int'(im);
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return DW'(mx + (3 * mn) / 8);
  endfunction

  // Engine stand-in: registers its operands twice, so the result shows up LAT cycles after issue.
  logic signed [DW-1:0] e1_re, e1_im, e2_re, e2_im;
  always @(posedge clk) begin
    e1_re <= o_eng_re;
    e1_im <= o_eng_im;
    e2_re <= e1_re;
    e2_im <= e1_im;
  end
  assign i_eng_mag = mag_f(e2_re, e2_im);

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [SBW-1:0] exp_q[$];
  int             m_state  = ST_IDLE;
  int             m_ptr    = 0;
  int             last_hs  = -100;
  int             m_cnt    = 0;
  int             hs_count = 0;
  logic [CHW-1:0] m_ch     = '0;
  logic [DW-1:0]  m_mag    = '0;
  logic [NCH-1:0] acc_mask = '0;

  always @(negedge clk) begin : mon
    logic [NCH-1:0] exp_rdy;
    logic [DW-1:0]  exp_re, exp_im;
    logic [SBW-1:0] e;
    logic           ev, inflight;
    int             g, c;
    acc_mask = '0;
    if (!rst_n) begin
      chk("rst_ready", 32'(o_req_ready), 32'd0);
      chk("rst_out_valid", 32'(o_out_valid), 32'd0);
      chk("rst_out_ch", 32'(o_out_ch), 32'd0);
      chk("rst_out_mag", 32'(o_out_mag), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_cnt", o_sample_cnt, 32'd0);
      chk("rst_eng_re", 32'(o_eng_re), 32'd0);
      chk("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
      exp_q.delete();
      m_state = ST_IDLE;
      m_ptr   = 0;
      last_hs = -100;
      m_cnt   = 0;
      m_ch    = '0;
      m_mag   = '0;
    end else begin
      inflight = (cyc - last_hs >= 1) && (cyc - last_hs <= LAT);
      g = -1;
      if (m_state == ST_RUN && i_enable) begin
        for (int i = 0; i < NCH; i++) begin
          c = (m_ptr + i) % NCH;
          if (g < 0 && i_req_valid[c] && i_ch_en[c]) g = c;
        end
      end
      exp_rdy = '0;
      exp_re  = '0;
      exp_im  = '0;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        exp_re     = re_a[g];
        exp_im     = im_a[g];
      end
      chk("ready", 32'(o_req_ready), 32'(exp_rdy));
      chk("eng_re", 32'(o_eng_re), 32'(exp_re));
      chk("eng_im", 32'(o_eng_im), 32'(exp_im));
      chk("busy", 32'(o_busy), 32'(m_state != ST_IDLE || inflight));
      chk("state", 32'(o_dbg_state), 32'(m_state));
      ev = (exp_q.size() > 0) && (int'(exp_q[0][63:32]) + LAT + 1 <= cyc);
      chk("out_valid", 32'(o_out_valid), 32'(ev));
      if (ev) begin
        e     = exp_q.pop_front();
        m_ch  = e[16 +: CHW];
        m_mag = e[15:0];
        m_cnt++;
      end
      chk("out_ch", 32'(o_out_ch), 32'(m_ch));
      chk("out_mag", 32'(o_out_mag), 32'(m_mag));
      chk("sample_cnt", o_sample_cnt, 32'(m_cnt));
      if (g >= 0) begin
        exp_q.push_back({32'(cyc), 14'd0, CHW'(g), mag_f(re_a[g], im_a[g])});
        last_hs     = cyc;
        m_ptr       = (g + 1) % NCH;
        acc_mask[g] = 1'b1;
        hs_count++;
      end
      case (m_state)
        ST_IDLE:  if (i_enable) m_state = ST_RUN;
        ST_RUN:   if (!i_enable) m_state = ST_DRAIN;
        default:  if (!inflight) m_state = ST_IDLE;
      endcase
    end
  end

  // ---------------- driver ----------------
  logic rand_mode = 1'b0;

  function automatic logic signed [DW-1:0] rnd_s();
    int v;
    v = int'($urandom_range(0, 16000)) - 8000;
    return DW'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target);
    for (int i = 0; i < 100 && hs_count < target; i++) step();
    chk("hs_wait", 32'(hs_count >= target), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && o_busy; i++) step();
    chk("idle_wait", 32'(o_busy), 32'd0);
  endtask

  // Random requesters: a channel only changes its sample once it is not valid or was just accepted.
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      for (int k = 0; k < NCH; k++) begin
        if (!i_req_valid[k] || acc_mask[k]) begin
          i_req_valid[k] = ($urandom_range(0, 3) != 0);
          re_a[k]        = rnd_s();
          im_a[k]        = rnd_s();
        end
      end
      if ($urandom_range(0, 15) == 0) i_ch_en = NCH'($urandom);
      if ($urandom_range(0, 24) == 0) i_enable = !i_enable;
    end
  end

  initial begin
    rst_n       = 1'b0;
    i_enable    = 1'b0;
    i_ch_en     = '1;
    i_req_valid = '1;
    for (int k = 0; k < NCH; k++) begin
      re_a[k] = rnd_s();
      im_a[k] = rnd_s();
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // Single channel: 100 - j40 -> 115, three cycles after the handshake.
    i_req_valid = 4'b0001;
    re_a[0]     = 16'sd100;
    im_a[0]     = -16'sd40;
    i_enable    = 1'b1;
    wait_hs(hs_count + 1);
    i_req_valid = '0;
    for (int i = 0; i < 10 && !o_out_valid; i++) step();
    chk("t2_ch", 32'(o_out_ch), 32'd0);
    chk("t2_mag", 32'(o_out_mag), 32'd115);
    repeat (3) step();

    // Round-robin across all channels; ch2 carries -8 + j64 -> 67.
    re_a[0] = 16'sd50;   im_a[0] = 16'sd7;
    re_a[1] = -16'sd300; im_a[1] = 16'sd12;
    re_a[2] = -16'sd8;   im_a[2] = 16'sd64;
    re_a[3] = 16'sd1000; im_a[3] = -16'sd999;
    i_req_valid = '1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (o_out_valid && o_out_ch == 2) chk("t3_ch2_mag", 32'(o_out_mag), 32'd67);
    end

    // Masked ch2 with valid high must never be granted.
    i_ch_en = 4'b1011;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("t4_ch2_ready", 32'(o_req_ready[2]), 32'd0);
    end

    // Drain after exactly two grants.
    i_enable = 1'b0;
    i_ch_en  = '1;
    wait_idle();
    i_enable = 1'b1;
    wait_hs(hs_count + 2);
    i_enable = 1'b0;
    wait_idle();
    chk("t5_state_idle", 32'(o_dbg_state), 32'(ST_IDLE));

    // Reset one cycle after a grant discards the in-flight sample.
    i_enable = 1'b1;
    wait_hs(hs_count + 1);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n    = 1'b1;
    i_enable = 1'b0;
    repeat (4) step();
    chk("t6_cnt", o_sample_cnt, 32'd0);

    // Random traffic with random masks and enable toggles.
    i_enable  = 1'b1;
    rand_mode = 1'b1;
    repeat (800) @(posedge clk);
    @(negedge clk);
    rand_mode = 1'b0;
    step();
    i_enable = 1'b0;
    wait_idle();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
